// File: rtl/riscv_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_core_pkg                                               |
// | Description : Shared checkpoint id/count types, checkpoint payload layout  |
// |               offsets and a small popcount helper.                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package riscv_core_pkg;

    localparam int c_cp_num = 8;
    localparam int c_cp_w   = $clog2(c_cp_num);

    typedef logic [c_cp_w-1:0] cp_id_t;
    typedef logic [c_cp_w:0]   cp_count_t;

    // Checkpoint payload layout, owned by rename; the queue treats it as opaque.
    localparam int c_cp_fl_front_lsb = 0;
    localparam int c_cp_fl_front_w   = 7;
    localparam int c_cp_al_front_lsb = c_cp_fl_front_lsb + c_cp_fl_front_w;
    localparam int c_cp_al_front_w   = 6;
    localparam int c_cp_bbt_lsb      = c_cp_al_front_lsb + c_cp_al_front_w;
    localparam int c_cp_bbt_w        = 8;
    localparam int c_cp_rmt_lsb      = c_cp_bbt_lsb + c_cp_bbt_w;
    localparam int c_cp_rmt_w        = 235;

    function automatic int unsigned cp_ones(input logic [7:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp_storage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cp_storage                                                   |
// | Description : NUM_CP x PAYLOAD_W checkpoint payload registers, PORTS write |
// |               ports, one asynchronous read port.                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cp_storage #(
    parameter int NUM_CP    = 8,
    parameter int PAYLOAD_W = 256,
    parameter int PORTS     = 2,
    localparam int CPW      = $clog2(NUM_CP)
) (
    input  logic                       clk,
    input  logic [PORTS-1:0]           i_wr_en,
    input  logic [PORTS*CPW-1:0]       i_wr_id,
    input  logic [PORTS*PAYLOAD_W-1:0] i_wr_data,
    input  logic [CPW-1:0]             i_rd_id,
    output logic [PAYLOAD_W-1:0]       o_rd_data
);

    logic [PAYLOAD_W-1:0] r_mem [NUM_CP];

    // Later slots overwrite earlier ones on a same-id collision.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PORTS; k++) begin
            if (i_wr_en[k]) begin
                r_mem[i_wr_id[k*CPW +: CPW]] <= i_wr_data[k*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_id];

endmodule
`default_nettype wire

// File: rtl/checkpoint_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : checkpoint_queue                                             |
// | Description : Circular queue of rename checkpoints for in-flight branches; |
// |               multi-port alloc, validate, in-order retire and recall.      |
// |               Define CP_PERF_CNT_EN to add the full-stall/recall counters. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module checkpoint_queue
    import riscv_core_pkg::*;
#(
    parameter int NUM_CP      = 8,
    parameter int PAYLOAD_W   = 256,
    parameter int AL_W        = 6,
    parameter int ALLOC_PORTS = 2,
    parameter int RES_PORTS   = 2,
    parameter int RETIRE_MAX  = 2,
    localparam int CPW        = $clog2(NUM_CP)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             ext_stall,
    input  logic [ALLOC_PORTS-1:0]           alloc_req,
    input  logic [ALLOC_PORTS*PAYLOAD_W-1:0] alloc_payload,
    input  logic [ALLOC_PORTS*AL_W-1:0]      alloc_al,
    output logic                             alloc_ready,
    output logic [ALLOC_PORTS*CPW-1:0]       alloc_id,
    input  logic [RES_PORTS-1:0]             validate,
    input  logic [RES_PORTS*CPW-1:0]         validated_id,
    input  logic                             recall,
    input  logic [CPW-1:0]                   recall_id,
    output logic [PAYLOAD_W-1:0]             recall_data,
    output logic [AL_W-1:0]                  oldest_al,
    output logic                             empty,
    output logic [CPW:0]                     count
`ifdef CP_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_full_stall,
    output logic [31:0]                      perf_recalls
`endif
);

    logic [CPW-1:0]   r_head;
    logic [CPW-1:0]   r_tail;
    logic [CPW:0]     r_count;
    logic [NUM_CP-1:0] r_validated;
    logic [AL_W-1:0]  r_al [NUM_CP];

    logic [CPW:0]     w_nreq;
    logic [CPW:0]     w_acc;
    logic             w_alloc_en;
    logic [CPW-1:0]   w_ofs;
    logic [CPW-1:0]   w_slot_id [ALLOC_PORTS];
    logic [ALLOC_PORTS-1:0] w_wr_en;

    logic [CPW:0]     w_nret;
    logic             w_run;
    logic [CPW-1:0]   w_scan;
    logic [CPW-1:0]   w_head_nxt;

    logic [NUM_CP-1:0] w_validated_nxt;
    logic [CPW-1:0]   w_vid;
    logic             w_stale;
    logic             w_squash;
    logic [CPW-1:0]   w_recall_dist;
    logic             w_recall_live;

    // One entry is always held spare so a full queue never aliases empty.
    assign w_nreq      = (CPW+1)'(cp_ones(8'(alloc_req)));
    assign alloc_ready = ({1'b0, r_count} + {1'b0, w_nreq}) <= (CPW+2)'(NUM_CP - 1);
    assign w_alloc_en  = alloc_ready & ~ext_stall & ~recall;
    assign w_acc       = w_alloc_en ? w_nreq : '0;

    always_comb begin
        w_ofs   = '0;
        w_wr_en = '0;
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            w_slot_id[k] = r_tail + w_ofs;
            w_wr_en[k]   = w_alloc_en & alloc_req[k];
            if (alloc_req[k]) begin
                w_ofs = w_ofs + CPW'(1);
            end
        end
    end

    for (genvar k = 0; k < ALLOC_PORTS; k++) begin : g_alloc_id
        assign alloc_id[k*CPW +: CPW] = w_slot_id[k];
    end

    // Retire scan sees only the validated bits registered before this edge.
    always_comb begin
        w_nret = '0;
        w_run  = 1'b1;
        w_scan = r_head;
        for (int i = 0; i < RETIRE_MAX; i++) begin
            w_scan = r_head + CPW'(i);
            if (w_run && ((CPW+1)'(i) < r_count) && r_validated[w_scan]) begin
                w_nret = w_nret + (CPW+1)'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_head_nxt = r_head + CPW'(w_nret);

    always_comb begin
        w_validated_nxt = r_validated;
        w_vid           = '0;
        w_stale         = 1'b0;
        w_squash        = 1'b0;
        for (int p = 0; p < RES_PORTS; p++) begin
            w_vid   = validated_id[p*CPW +: CPW];
            w_stale = 1'b0;
            for (int k = 0; k < ALLOC_PORTS; k++) begin
                if (w_wr_en[k] && (w_slot_id[k] == w_vid)) begin
                    w_stale = 1'b1;
                end
            end
            w_squash = recall && (CPW'(w_vid - recall_id) < CPW'(r_tail - recall_id));
            if (validate[p] && !w_stale && !w_squash) begin
                w_validated_nxt[w_vid] = 1'b1;
            end
        end
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            if (w_wr_en[k]) begin
                w_validated_nxt[w_slot_id[k]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_validated <= '0;
            for (int i = 0; i < NUM_CP; i++) begin
                r_al[i] <= '0;
            end
        end else begin
            r_head      <= w_head_nxt;
            r_validated <= w_validated_nxt;
            if (recall) begin
                r_tail  <= recall_id;
                r_count <= {1'b0, CPW'(recall_id - w_head_nxt)};
            end else begin
                r_tail  <= r_tail + CPW'(w_acc);
                r_count <= r_count + w_acc - w_nret;
            end
            for (int k = 0; k < ALLOC_PORTS; k++) begin
                if (w_wr_en[k]) begin
                    r_al[w_slot_id[k]] <= alloc_al[k*AL_W +: AL_W];
                end
            end
        end
    end

    cp_storage #(
        .NUM_CP    (NUM_CP),
        .PAYLOAD_W (PAYLOAD_W),
        .PORTS     (ALLOC_PORTS)
    ) u_storage (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_id   (alloc_id),
        .i_wr_data (alloc_payload),
        .i_rd_id   (recall_id),
        .o_rd_data (recall_data)
    );

    assign oldest_al = r_al[r_head];
    assign empty     = (r_count == '0);
    assign count     = r_count;

`ifdef CP_PERF_CNT_EN
    logic [31:0] r_perf_full_stall;
    logic [31:0] r_perf_recalls;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_full_stall <= '0;
            r_perf_recalls    <= '0;
        end else begin
            if ((w_nreq != '0) && !alloc_ready && (r_perf_full_stall != '1)) begin
                r_perf_full_stall <= r_perf_full_stall + 32'd1;
            end
            if (recall && (r_perf_recalls != '1)) begin
                r_perf_recalls <= r_perf_recalls + 32'd1;
            end
        end
    end

    assign perf_full_stall = r_perf_full_stall;
    assign perf_recalls    = r_perf_recalls;
`endif

    assign w_recall_dist = recall_id - r_head;
    assign w_recall_live = ({1'b0, w_recall_dist} < r_count);

    a_recall_live: assert property (@(posedge clk) disable iff (!reset_n) recall |-> w_recall_live)
        else $error("recall_id outside the live checkpoint window");

endmodule
`default_nettype wire

// File: tb/tb_checkpoint_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_checkpoint_queue                                          |
// | Description : Directed, table-driven self-checking bench for              |
// |               checkpoint_queue (honours CP_PERF_CNT_EN).                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_checkpoint_queue;

    localparam int c_nrows = 32;

    logic         clk;
    logic         reset_n;
    logic         ext_stall;
    logic [1:0]   alloc_req;
    logic [511:0] alloc_payload;
    logic [11:0]  alloc_al;
    logic         alloc_ready;
    logic [5:0]   alloc_id;
    logic [1:0]   validate;
    logic [5:0]   validated_id;
    logic         recall;
    logic [2:0]   recall_id;
    logic [255:0] recall_data;
    logic [5:0]   oldest_al;
    logic         empty;
    logic [3:0]   count;
`ifdef CP_PERF_CNT_EN
    logic [31:0]  perf_full_stall;
    logic [31:0]  perf_recalls;
`endif

    checkpoint_queue dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ext_stall     (ext_stall),
        .alloc_req     (alloc_req),
        .alloc_payload (alloc_payload),
        .alloc_al      (alloc_al),
        .alloc_ready   (alloc_ready),
        .alloc_id      (alloc_id),
        .validate      (validate),
        .validated_id  (validated_id),
        .recall        (recall),
        .recall_id     (recall_id),
        .recall_data   (recall_data),
        .oldest_al     (oldest_al),
        .empty         (empty),
        .count         (count)
`ifdef CP_PERF_CNT_EN
        ,
        .perf_full_stall (perf_full_stall),
        .perf_recalls    (perf_recalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic       stall;
        logic [1:0] val;
        int         vid0;
        int         vid1;
        logic       rcl;
        int         rid;
        logic       e_rdy;
        int         e_id0;
        int         e_id1;
        int         e_cnt;
        int         e_oal;
        int         e_tag;
    } vec_t;

    vec_t tv [c_nrows];
    int   n_cmp;
    int   n_err;

    function automatic vec_t mk(input logic [1:0] req, input logic stall, input logic [1:0] val,
                                input int vid0, input int vid1, input logic rcl, input int rid,
                                input logic rdy, input int id0, input int id1, input int cnt,
                                input int oal, input int tag);
        vec_t v;
        v.req = req;  v.stall = stall; v.val = val; v.vid0 = vid0; v.vid1 = vid1;
        v.rcl = rcl;  v.rid = rid;     v.e_rdy = rdy; v.e_id0 = id0; v.e_id1 = id1;
        v.e_cnt = cnt; v.e_oal = oal;  v.e_tag = tag;
        return v;
    endfunction

    // Payload carries the row and id that wrote it, so a recall can be traced.
    function automatic logic [255:0] pf(input int tag);
        return {8{32'hC0DE_0000 ^ 32'(tag)}};
    endfunction

    task automatic chk(input string nm, input int row, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %0h expected %0h", row, nm, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //              req  st val  v0 v1 rc rid rdy id0 id1 cnt oal tag
        tv[0]  = mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 0, -1);
        tv[1]  = mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 1, 2, 3, 2, 20, -1);
        tv[2]  = mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 1, 4, 5, 4, 20, -1);
        tv[3]  = mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 6, 7, 6, 20, -1);
        tv[4]  = mk(2'b01, 0, 2'b00, 0, 0, 0, 0, 1, 6, 0, 6, 20, -1);
        tv[5]  = mk(2'b00, 0, 2'b11, 0, 1, 0, 0, 1, 0, 0, 7, 20, -1);
        tv[6]  = mk(2'b00, 0, 2'b01, 2, 0, 0, 0, 1, 0, 0, 7, 20, -1);
        tv[7]  = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 5, 22, -1);
        tv[8]  = mk(2'b00, 0, 2'b01, 4, 0, 0, 0, 1, 0, 0, 4, 23, -1);
        tv[9]  = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4, 23, -1);
        tv[10] = mk(2'b00, 0, 2'b01, 3, 0, 0, 0, 1, 0, 0, 4, 23, -1);
        tv[11] = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4, 23, -1);
        tv[12] = mk(2'b11, 0, 2'b01, 5, 0, 0, 0, 1, 7, 0, 2, 25, -1);
        tv[13] = mk(2'b01, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 4, 25, -1);
        tv[14] = mk(2'b11, 0, 2'b01, 1, 0, 1, 0, 1, 2, 3, 4, 26, 12*16 + 0);
        tv[15] = mk(2'b11, 1, 2'b01, 6, 0, 0, 0, 1, 0, 1, 2, 26, -1);
        tv[16] = mk(2'b11, 1, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2, 26, -1);
        tv[17] = mk(2'b11, 0, 2'b01, 0, 0, 0, 0, 1, 0, 1, 1, 27, -1);
        tv[18] = mk(2'b00, 0, 2'b01, 7, 0, 0, 0, 1, 0, 0, 3, 27, -1);
        tv[19] = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3, 27, -1);
        tv[20] = mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 1, 2, 3, 2, 20, -1);
        tv[21] = mk(2'b01, 0, 2'b00, 0, 0, 0, 0, 1, 4, 0, 4, 20, -1);
        tv[22] = mk(2'b00, 0, 2'b11, 1, 2, 0, 0, 1, 0, 0, 5, 20, -1);
        tv[23] = mk(2'b00, 0, 2'b11, 3, 4, 0, 0, 1, 0, 0, 5, 20, -1);
        tv[24] = mk(2'b00, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0, 5, 20, -1);
        tv[25] = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 5, 20, -1);
        tv[26] = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3, 22, -1);
        tv[27] = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, 24, -1);
        tv[28] = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 25, -1);
        tv[29] = mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 1, 5, 6, 0, 25, -1);
        tv[30] = mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 2, 25, -1);
        tv[31] = mk(2'b01, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 4, 25, -1);

        reset_n       = 1'b0;
        ext_stall     = 1'b0;
        alloc_req     = '0;
        alloc_payload = '0;
        alloc_al      = '0;
        validate      = '0;
        validated_id  = '0;
        recall        = 1'b0;
        recall_id     = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int r = 0; r < c_nrows; r++) begin
            @(negedge clk);
            alloc_req     = tv[r].req;
            ext_stall     = tv[r].stall;
            validate      = tv[r].val;
            validated_id  = {3'(tv[r].vid1), 3'(tv[r].vid0)};
            recall        = tv[r].rcl;
            recall_id     = 3'(tv[r].rid);
            alloc_payload = {pf(r*16 + tv[r].e_id1), pf(r*16 + tv[r].e_id0)};
            alloc_al      = {6'(20 + tv[r].e_id1), 6'(20 + tv[r].e_id0)};
            #1;
            chk("alloc_ready", r, 256'(alloc_ready), 256'(tv[r].e_rdy));
            chk("count", r, 256'(count), 256'(tv[r].e_cnt));
            chk("empty", r, 256'(empty), 256'(tv[r].e_cnt == 0));
            chk("oldest_al", r, 256'(oldest_al), 256'(tv[r].e_oal));
            if (tv[r].req[0]) chk("alloc_id0", r, 256'(alloc_id[2:0]), 256'(tv[r].e_id0));
            if (tv[r].req[1]) chk("alloc_id1", r, 256'(alloc_id[5:3]), 256'(tv[r].e_id1));
            if (tv[r].e_tag >= 0) chk("recall_data", r, recall_data, pf(tv[r].e_tag));
        end

        // Asynchronous reset in the middle of a cycle with five live entries.
        @(negedge clk);
        alloc_req = 2'b11;
        validate  = '0;
        recall    = 1'b0;
        ext_stall = 1'b0;
        #1;
        chk("pre_reset_count", 100, 256'(count), 256'(5));
        chk("pre_reset_empty", 100, 256'(empty), 256'(0));
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_count", 101, 256'(count), 256'(0));
        chk("async_empty", 101, 256'(empty), 256'(1));
        chk("async_ready", 101, 256'(alloc_ready), 256'(1));
        chk("async_oldest_al", 101, 256'(oldest_al), 256'(0));
        chk("async_alloc_id", 101, 256'(alloc_id), 256'(6'b001_000));
`ifdef CP_PERF_CNT_EN
        chk("perf_full_stall", 101, 256'(perf_full_stall), 256'(0));
        chk("perf_recalls", 101, 256'(perf_recalls), 256'(0));
`endif
        @(negedge clk);
        alloc_req = '0;
        reset_n   = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
